// File: rtl/hwpe_stream_scm_mp_pkg.sv
// Shared constants for the multi-port latch SCM.
// Imported by the top and the read-port slice.
package hwpe_stream_scm_mp_pkg;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/hwpe_stream_scm_rport.sv
// One SCM read port: address register, OOR/valid mask
// and byte bypass from the pending write.
module hwpe_stream_scm_rport
  import hwpe_stream_scm_mp_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int unsigned NB_BYTES   = DATA_WIDTH / BYTE_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ReadEnable,
  input  logic [ADDR_WIDTH-1:0]                ReadAddr,
  output logic [DATA_WIDTH-1:0]                ReadData,
  input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] Mem,
  input  logic [NUM_WORDS-1:0]                 Vld,
  input  logic                                 WPend,
  input  logic [ADDR_WIDTH-1:0]                WAddr,
  input  logic [DATA_WIDTH-1:0]                WData,
  input  logic [NB_BYTES-1:0]                  WBe
);

  localparam logic [ADDR_WIDTH:0] NumWords =
    (ADDR_WIDTH+1)'(NUM_WORDS);

  logic [ADDR_WIDTH-1:0] RAddrReg;
  logic                  inRange;
  logic                  live;
  logic                  hit;
  logic [DATA_WIDTH-1:0] word;

  always_ff @(posedge clk) begin
    if (rst) begin
      RAddrReg <= '0;
    end else if (ReadEnable) begin
      RAddrReg <= ReadAddr;
    end
  end

  assign inRange = {1'b0, RAddrReg} < NumWords;
  assign live    = inRange && Vld[RAddrReg];
  assign hit     = live && WPend && (WAddr == RAddrReg);

  // Pending-write bytes override the latch so the
  // read sees them before the latch window closes.
  always_comb begin
    word = '0;
    if (live) word = Mem[RAddrReg];
    for (int b = 0; b < NB_BYTES; b++) begin
      if (hit && WBe[b]) begin
        word[b*BYTE_W +: BYTE_W] = WData[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign ReadData = word;

endmodule

// File: rtl/tc_clk_gating.sv
// Glitch-free clock gate: enable latched while clk is low.
// Behavioural model of the technology ICG cell.
module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic enLatch;

  always_latch begin
    if (!clk_i) enLatch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & enLatch;

endmodule

// File: rtl/hwpe_stream_scm_mp.sv
// Latch-based SCM, NB_RPORTS read ports, byte-enabled writes,
// per-word valid bits and write-to-read bypass.
module hwpe_stream_scm_mp
  import hwpe_stream_scm_mp_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NB_RPORTS  = 2,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int unsigned NB_BYTES   = DATA_WIDTH / BYTE_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NB_RPORTS-1:0]                 ReadEnable,
  input  logic [NB_RPORTS-1:0][ADDR_WIDTH-1:0] ReadAddr,
  output logic [NB_RPORTS-1:0][DATA_WIDTH-1:0] ReadData,
  input  logic                                 WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                WriteAddr,
  input  logic [DATA_WIDTH-1:0]                WriteData,
  input  logic [NB_BYTES-1:0]                  WriteBe,
  output logic                                 WriteOor
);

  localparam logic [ADDR_WIDTH:0] NumWords =
    (ADDR_WIDTH+1)'(NUM_WORDS);

  logic                                 wInRange;
  logic                                 wPendD;
  logic                                 WPend;
  logic [ADDR_WIDTH-1:0]                WAddrReg;
  logic [DATA_WIDTH-1:0]                WDataReg;
  logic [NB_BYTES-1:0]                  WBeReg;
  logic [NUM_WORDS-1:0]                 Vld;
  logic [NUM_WORDS-1:0]                 wordEnD;
  logic [NUM_WORDS-1:0]                 wordClk;
  logic                                 globalClk;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] Mem;

  assign wInRange = {1'b0, WriteAddr} < NumWords;
  assign wPendD   = WriteEnable && wInRange
                  && (|WriteBe) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      WPend    <= 1'b0;
      WriteOor <= 1'b0;
    end else begin
      WPend    <= wPendD;
      WriteOor <= WriteEnable && !wInRange;
    end
  end

  always_ff @(posedge clk) begin
    if (wPendD) begin
      WAddrReg <= WriteAddr;
      WDataReg <= WriteData;
      WBeReg   <= WriteBe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Vld <= '0;
    end else if (WPend) begin
      Vld[WAddrReg] <= 1'b1;
    end
  end

  // The ICG latches its enable in the low phase, so it is fed
  // the next-cycle values; the pulse lands in the WPend cycle.
  tc_clk_gating i_gate_global (
    .clk_i     (clk),
    .en_i      (wPendD),
    .test_en_i (1'b0),
    .clk_o     (globalClk)
  );

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    assign wordEnD[w] = (WriteAddr == ADDR_WIDTH'(w));

    tc_clk_gating i_gate_word (
      .clk_i     (globalClk),
      .en_i      (wordEnD[w]),
      .test_en_i (1'b0),
      .clk_o     (wordClk[w])
    );

    for (genvar b = 0; b < NB_BYTES; b++) begin : g_byte
      logic [BYTE_W-1:0] q;

      always_latch begin
        if (wordClk[w] && WBeReg[b]) begin
          q <= WDataReg[b*BYTE_W +: BYTE_W];
        end
      end

      assign Mem[w][b*BYTE_W +: BYTE_W] = q;
    end
  end

  for (genvar p = 0; p < NB_RPORTS; p++) begin : g_rport
    hwpe_stream_scm_rport #(
      .NUM_WORDS  (NUM_WORDS),
      .DATA_WIDTH (DATA_WIDTH)
    ) i_rport (
      .clk        (clk),
      .rst        (rst),
      .ReadEnable (ReadEnable[p]),
      .ReadAddr   (ReadAddr[p]),
      .ReadData   (ReadData[p]),
      .Mem        (Mem),
      .Vld        (Vld),
      .WPend      (WPend),
      .WAddr      (WAddrReg),
      .WData      (WDataReg),
      .WBe        (WBeReg)
    );
  end

endmodule

// File: tb/tb_hwpe_stream_scm_mp.sv
// Bench for hwpe_stream_scm_mp (24 words, 2 read ports):
// constant vector table plus model-driven sequences.
module tb_hwpe_stream_scm_mp;

  localparam int NW = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      ReadEnable;
  logic [1:0][4:0] ReadAddr;
  logic [1:0][31:0] ReadData;
  logic            WriteEnable;
  logic [4:0]      WriteAddr;
  logic [31:0]     WriteData;
  logic [3:0]      WriteBe;
  logic            WriteOor;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hwpe_stream_scm_mp #(
    .NUM_WORDS  (NW),
    .DATA_WIDTH (32),
    .NB_RPORTS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteBe     (WriteBe),
    .WriteOor    (WriteOor)
  );

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          re0;
    logic [4:0]  ra0;
    bit          re1;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eo;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eo;
  } exp_t;

  vec_t  tab [13];
  exp_t  sb [$];

  logic [31:0] mdl [NW];
  bit          mv  [NW];
  logic [4:0]  held [2];

  function automatic logic [31:0] mread(
    input logic [4:0] a, input bit we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    if (a >= 5'(NW)) return '0;
    if (!mv[a]) return '0;
    r = mdl[a];
    if (we && wa == a && be != 4'h0)
      for (int b = 0; b < 4; b++)
        if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic cmp(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".rd0"}, ReadData[0], e.e0);
      cmp({e.tag, ".rd1"}, ReadData[1], e.e1);
      cmp({e.tag, ".oor"}, 32'(WriteOor), 32'(e.eo));
    end
  endtask

  task automatic issue(input vec_t v, input bit useTab,
                       input string tag);
    exp_t e;
    WriteEnable   = v.we;
    WriteAddr     = v.wa;
    WriteData     = v.wd;
    WriteBe       = v.be;
    ReadEnable[0] = v.re0;
    ReadAddr[0]   = v.ra0;
    ReadEnable[1] = v.re1;
    ReadAddr[1]   = v.ra1;
    if (v.re0) held[0] = v.ra0;
    if (v.re1) held[1] = v.ra1;
    e.tag = tag;
    if (useTab) begin
      e.e0 = v.e0;
      e.e1 = v.e1;
      e.eo = v.eo;
    end else begin
      e.e0 = mread(held[0], v.we, v.wa, v.wd, v.be);
      e.e1 = mread(held[1], v.we, v.wa, v.wd, v.be);
      e.eo = v.we && (v.wa >= 5'(NW));
    end
    sb.push_back(e);
    if (v.we && v.wa < 5'(NW) && v.be != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (v.be[b]) mdl[v.wa][b*8 +: 8] = v.wd[b*8 +: 8];
      mv[v.wa] = 1'b1;
    end
    step();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) mv[i] = 1'b0;
    held[0] = '0;
    held[1] = '0;
  endtask

  function automatic vec_t mk(
    input bit we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [3:0] be, input bit re0, input logic [4:0] ra0,
    input bit re1, input logic [4:0] ra1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
    v.e0 = '0; v.e1 = '0; v.eo = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t v;
    tab[0]  = '{0, 0,  0,            0, 1, 0,  1, 31,
                0,            0,            0};
    tab[1]  = '{1, 5,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0,
                0,            0,            0};
    tab[2]  = '{0, 0,  0,            0, 0, 0,  0, 0,
                0,            0,            0};
    tab[3]  = '{0, 0,  0,            0, 1, 5,  1, 5,
                32'hDEADBEEF, 32'hDEADBEEF, 0};
    tab[4]  = '{1, 5,  32'h11223344, 4'b0101, 1, 5, 0, 0,
                32'hDE22BE44, 32'hDE22BE44, 0};
    tab[5]  = '{0, 0,  0,            0, 0, 0,  0, 0,
                32'hDE22BE44, 32'hDE22BE44, 0};
    tab[6]  = '{1, 30, 32'hFFFFFFFF, 4'hF, 1, 30, 0, 0,
                0,            32'hDE22BE44, 1};
    tab[7]  = '{0, 0,  0,            0, 0, 0,  1, 30,
                0,            0,            0};
    tab[8]  = '{1, 23, 32'hA5A5A5A5, 4'hF, 1, 23, 0, 0,
                0,            0,            0};
    tab[9]  = '{0, 0,  0,            0, 1, 23, 1, 5,
                32'hA5A5A5A5, 32'hDE22BE44, 0};
    tab[10] = '{1, 5,  0,            4'h0, 1, 5, 0, 0,
                32'hDE22BE44, 32'hDE22BE44, 0};
    tab[11] = '{1, 23, 32'h00000077, 4'b0001, 1, 0, 1, 23,
                0,            32'hA5A5A577, 0};
    tab[12] = '{0, 0,  0,            0, 0, 0,  0, 0,
                0,            32'hA5A5A577, 0};

    for (int i = 0; i < NW; i++) mdl[i] = '0;
    model_reset();
    rst = 1'b1;
    WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
    WriteBe = '0; ReadEnable = '0; ReadAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("reset.rd0", ReadData[0], 32'h0);
    cmp("reset.rd1", ReadData[1], 32'h0);
    cmp("reset.oor", 32'(WriteOor), 32'h0);

    for (int i = 0; i < 13; i++)
      issue(tab[i], 1'b1, $sformatf("vec%0d", i));

    // back-to-back writes, both ports read the previous word
    for (int k = 0; k < NW; k++) begin
      v = mk(1'b1, 5'(k), (32'h01010101 * (k + 1)) ^ 32'hC0DE0000,
             4'hF, k > 0, 5'(k - 1), k > 0, 5'(k - 1));
      issue(v, 1'b0, $sformatf("b2b%0d", k));
    end
    issue(mk(0, 0, 0, 0, 1, 23, 1, 23), 1'b0, "b2b_last");
    issue(mk(0, 0, 0, 0, 1, 5, 1, 0), 1'b0, "b2b_reread");

    // reset lands in the cycle the write to 7 is pending
    issue(mk(1, 7, 32'h77777777, 4'hF, 0, 0, 0, 0), 1'b0, "abort_wr");
    WriteEnable = 1'b0;
    ReadEnable  = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cmp("abort.rd0", ReadData[0], 32'h0);
    issue(mk(0, 0, 0, 0, 1, 7, 1, 5), 1'b0, "abort_rd");
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "abort_hold");
    issue(mk(1, 7, 32'h12345678, 4'hF, 0, 0, 0, 0), 1'b0, "rewr");
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rewr_idle");
    issue(mk(0, 0, 0, 0, 1, 7, 1, 7), 1'b0, "rewr_rd");
    cmp("rewr.abs", ReadData[0], 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
